// File: rtl/order_strategy_engine_if.sv
// Quote feed and trade report bundle between the LFSR price source and the strategy engine.
// trade_valid is a one-cycle fill pulse with no backpressure; the fill fields hold between pulses.
interface order_strategy_engine_if;
    logic [7:0]  buy_price;
    logic [7:0]  sell_price;
    logic        trade_valid;
    logic        trade_side;
    logic [7:0]  trade_price;
    logic        long_pos;
    logic [7:0]  entry_price;
    logic [15:0] pnl;
    logic [15:0] trade_count;
    logic [1:0]  state;

    modport slave (
        input  buy_price, sell_price,
        output trade_valid, trade_side, trade_price, long_pos,
               entry_price, pnl, trade_count, state
    );

    modport master (
        output buy_price, sell_price,
        input  trade_valid, trade_side, trade_price, long_pos,
               entry_price, pnl, trade_count, state
    );
endinterface

// File: rtl/order_strategy_engine.sv
// Single-unit long-only strategy: buys at the ask below a threshold, sells at the bid on
// take-profit or stop-loss, then ignores a fixed number of new quotes before re-arming.
module order_strategy_engine #(
    parameter int BUY_THRESH  = 60,
    parameter int TAKE_PROFIT = 8,
    parameter int STOP_LOSS   = 6,
    parameter int COOLDOWN_Q  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    order_strategy_engine_if.slave bus
);
    typedef enum logic [1:0] {
        ST_FLAT     = 2'd0,
        ST_LONG     = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic [8:0]  BUY9    = 9'(BUY_THRESH);
    localparam logic [8:0]  TP9     = 9'(TAKE_PROFIT);
    localparam logic [8:0]  SL9     = 9'(STOP_LOSS);
    localparam logic [15:0] CD_INIT = 16'(COOLDOWN_Q);

    logic [7:0]  q_bid, q_ask;
    logic        q_new, seen;

    state_t      state_r, state_n;
    logic [7:0]  entry_r, entry_n;
    logic        long_r, long_n;
    logic [15:0] pnl_r, pnl_n;
    logic [15:0] count_r, count_n;
    logic [15:0] cd_r, cd_n;
    logic        tv_r, tv_n;
    logic        side_r, side_n;
    logic [7:0]  price_r, price_n;

    logic [8:0]  diff;
    logic [16:0] pnl_sum;
    logic [15:0] pnl_sat;
    logic [15:0] count_inc;
    logic        tp_hit, sl_hit;

    // Quote stage: the first sample after reset is always treated as new.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_bid <= 8'd0;
            q_ask <= 8'd0;
            seen  <= 1'b0;
            q_new <= 1'b0;
        end else begin
            q_bid <= bus.buy_price;
            q_ask <= bus.sell_price;
            seen  <= 1'b1;
            q_new <= !seen || (bus.buy_price != q_bid) || (bus.sell_price != q_ask);
        end
    end

    // All price comparisons are 9 bits wide so entry + offset cannot wrap.
    always_comb begin
        tp_hit    = {1'b0, q_bid} >= ({1'b0, entry_r} + TP9);
        sl_hit    = ({1'b0, q_bid} + SL9) <= {1'b0, entry_r};
        diff      = {1'b0, q_bid} - {1'b0, entry_r};
        pnl_sum   = {pnl_r[15], pnl_r} + {{8{diff[8]}}, diff};
        if (pnl_sum[16] != pnl_sum[15]) begin
            pnl_sat = pnl_sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            pnl_sat = pnl_sum[15:0];
        end
        count_inc = (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
    end

    always_comb begin
        state_n = state_r;
        entry_n = entry_r;
        long_n  = long_r;
        pnl_n   = pnl_r;
        count_n = count_r;
        cd_n    = cd_r;
        tv_n    = 1'b0;
        side_n  = side_r;
        price_n = price_r;
        if (q_new) begin
            case (state_r)
                ST_FLAT: begin
                    if ({1'b0, q_ask} <= BUY9) begin
                        tv_n    = 1'b1;
                        side_n  = 1'b0;
                        price_n = q_ask;
                        entry_n = q_ask;
                        long_n  = 1'b1;
                        count_n = count_inc;
                        state_n = ST_LONG;
                    end
                end
                ST_LONG: begin
                    if (tp_hit || sl_hit) begin
                        tv_n    = 1'b1;
                        side_n  = 1'b1;
                        price_n = q_bid;
                        pnl_n   = pnl_sat;
                        entry_n = 8'd0;
                        long_n  = 1'b0;
                        count_n = count_inc;
                        cd_n    = CD_INIT;
                        state_n = (CD_INIT == 16'd0) ? ST_FLAT : ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    // The quote that empties the counter is consumed, not evaluated.
                    cd_n = (cd_r == 16'd0) ? 16'd0 : cd_r - 16'd1;
                    if (cd_r <= 16'd1) begin
                        state_n = ST_FLAT;
                    end
                end
                default: state_n = ST_FLAT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FLAT;
            entry_r <= 8'd0;
            long_r  <= 1'b0;
            pnl_r   <= 16'd0;
            count_r <= 16'd0;
            cd_r    <= 16'd0;
            tv_r    <= 1'b0;
            side_r  <= 1'b0;
            price_r <= 8'd0;
        end else begin
            state_r <= state_n;
            entry_r <= entry_n;
            long_r  <= long_n;
            pnl_r   <= pnl_n;
            count_r <= count_n;
            cd_r    <= cd_n;
            tv_r    <= tv_n;
            side_r  <= side_n;
            price_r <= price_n;
        end
    end

    assign bus.trade_valid = tv_r;
    assign bus.trade_side  = side_r;
    assign bus.trade_price = price_r;
    assign bus.long_pos    = long_r;
    assign bus.entry_price = entry_r;
    assign bus.pnl         = pnl_r;
    assign bus.trade_count = count_r;
    assign bus.state       = state_r;
endmodule

// File: tb/tb_order_strategy_engine.sv
// Bench for order_strategy_engine: directed quotes with hand-computed fills checked by a
// queue-based monitor, plus a long losing run on a second instance for saturation.
module tb_order_strategy_engine;
  localparam logic [1:0] S_FLAT = 2'd0;
  localparam logic [1:0] S_LONG = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  order_strategy_engine_if bus();
  order_strategy_engine_if bus2();

  order_strategy_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  order_strategy_engine #(
    .BUY_THRESH  (90),
    .TAKE_PROFIT (8),
    .STOP_LOSS   (1),
    .COOLDOWN_Q  (0)
  ) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [51:0] exp_q[$];
  logic pos_seen = 1'b0;

  function automatic logic [51:0] pk(input logic side, input logic [7:0] price, input logic lp,
                                     input logic [7:0] ent, input logic [15:0] p,
                                     input logic [15:0] cnt, input logic [1:0] st);
    return {side, price, lp, ent, p, cnt, st};
  endfunction

  function automatic logic [51:0] act1();
    return pk(bus.trade_side, bus.trade_price, bus.long_pos, bus.entry_price,
              bus.pnl, bus.trade_count, bus.state);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic quote(input logic [7:0] b, input logic [7:0] a);
    bus.buy_price = b;
    bus.sell_price = a;
    @(negedge clk);
  endtask

  // Leaves the bench one negedge after the FSM has acted on this quote.
  task automatic q_settle(input logic [7:0] b, input logic [7:0] a);
    quote(b, a);
    @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending fills expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (bus.trade_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_fill: got side=%0d price=%0d expected no fill",
                     bus.trade_side, bus.trade_price);
          end else begin
            check("fill", 64'(act1()), 64'(exp_q.pop_front()));
          end
        end
        if (!bus2.pnl[15] && bus2.pnl != 16'd0) pos_seen = 1'b1;
      end
    join_none

    reset = 1'b1;
    bus.buy_price = 8'd70;
    bus.sell_price = 8'd58;
    bus2.buy_price = 8'd0;
    bus2.sell_price = 8'd255;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bus.trade_valid, act1()}), 64'd0);

    // Entry fill two cycles after the first sample.
    exp_q.push_back(pk(1'b0, 8'd58, 1'b1, 8'd58, 16'd0, 16'd1, S_LONG));
    reset = 1'b0;
    @(negedge clk);
    check("entry_latency_1", 64'(bus.trade_valid), 64'd0);
    @(negedge clk);
    check("entry_latency_2", 64'(bus.trade_valid), 64'd1);
    repeat (4) @(negedge clk);
    check("hold_long", 64'({bus.long_pos, bus.entry_price, bus.trade_count, bus.state}),
          64'({1'b1, 8'd58, 16'd1, S_LONG}));
    drain();

    // Take-profit boundary: 65 stays, 66 exits.
    q_settle(8'd65, 8'd70);
    check("below_tp", 64'({bus.state, bus.long_pos, bus.trade_count}), 64'({S_LONG, 1'b1, 16'd1}));
    exp_q.push_back(pk(1'b1, 8'd66, 1'b0, 8'd0, 16'd8, 16'd2, S_COOL));
    q_settle(8'd66, 8'd70);
    drain();

    // Cooldown swallows two cheap quotes, the third buys.
    q_settle(8'd70, 8'd55);
    check("cool_1", 64'({bus.state, bus.trade_count}), 64'({S_COOL, 16'd2}));
    q_settle(8'd71, 8'd55);
    check("cool_2", 64'({bus.state, bus.trade_count}), 64'({S_FLAT, 16'd2}));
    exp_q.push_back(pk(1'b0, 8'd55, 1'b1, 8'd55, 16'd8, 16'd3, S_LONG));
    q_settle(8'd72, 8'd55);
    drain();

    // Stop-loss from 55: 50 holds, 49 exits with pnl 8-6=2.
    q_settle(8'd50, 8'd80);
    check("above_sl", 64'({bus.state, bus.trade_count}), 64'({S_LONG, 16'd3}));
    exp_q.push_back(pk(1'b1, 8'd49, 1'b0, 8'd0, 16'd2, 16'd4, S_COOL));
    q_settle(8'd49, 8'd80);
    drain();

    // Back-to-back quotes: two cooldown quotes then ask 61 just above threshold.
    quote(8'd48, 8'd90);
    quote(8'd47, 8'd90);
    quote(8'd70, 8'd61);
    @(negedge clk);
    check("ask_above_thresh", 64'({bus.state, bus.trade_count}), 64'({S_FLAT, 16'd4}));
    exp_q.push_back(pk(1'b0, 8'd60, 1'b1, 8'd60, 16'd2, 16'd5, S_LONG));
    q_settle(8'd70, 8'd60);
    drain();

    // Stop-loss boundary from 60: 55 holds, 54 exits, pnl 2-6=-4.
    q_settle(8'd55, 8'd70);
    check("sl_boundary_hold", 64'({bus.state, bus.trade_count}), 64'({S_LONG, 16'd5}));
    exp_q.push_back(pk(1'b1, 8'd54, 1'b0, 8'd0, 16'hFFFC, 16'd6, S_COOL));
    q_settle(8'd54, 8'd70);
    drain();

    exp_q.push_back(pk(1'b0, 8'd50, 1'b1, 8'd50, 16'hFFFC, 16'd7, S_LONG));
    quote(8'd53, 8'd90);
    quote(8'd52, 8'd90);
    quote(8'd70, 8'd50);
    @(negedge clk);
    drain();

    // Reset while long, coincident with a take-profit quote.
    reset = 1'b1;
    bus.buy_price = 8'd60;
    bus.sell_price = 8'd55;
    @(negedge clk);
    check("reset_mid_long", 64'({bus.trade_valid, act1()}), 64'd0);
    exp_q.push_back(pk(1'b0, 8'd55, 1'b1, 8'd55, 16'd0, 16'd1, S_LONG));
    reset = 1'b0;
    @(negedge clk);
    check("requote_latency_1", 64'(bus.trade_valid), 64'd0);
    @(negedge clk);
    drain();

    // Saturation: alternating buy at 86 / sell at 0, one fill per cycle.
    for (int i = 0; i < 65534; i++) begin
      if (i[0]) begin
        bus2.buy_price = 8'd0;
        bus2.sell_price = 8'd200;
      end else begin
        bus2.buy_price = 8'd200;
        bus2.sell_price = 8'd86;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("sat_count_65534", 64'(bus2.trade_count), 64'd65534);
    check("sat_pnl_clamp", 64'(bus2.pnl), 64'h8000);
    bus2.buy_price = 8'd200;
    bus2.sell_price = 8'd86;
    @(negedge clk);
    bus2.buy_price = 8'd0;
    bus2.sell_price = 8'd200;
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("sat_count_hold", 64'(bus2.trade_count), 64'd65535);
    check("sat_pnl_final", 64'(bus2.pnl), 64'h8000);
    check("sat_last_sell", 64'({bus2.trade_side, bus2.trade_price, bus2.state}),
          64'({1'b1, 8'd0, S_FLAT}));
    check("pnl_never_positive", 64'(pos_seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/order_strategy_engine.md
# order_strategy_engine

Downstream consumer of the LFSR price feed. Samples `buy_price`/`sell_price` every `clk`, detects each new quote, and runs a single-unit long-only trading FSM against it: it enters at the ask, exits at the bid on take-profit or stop-loss, then cools down. It reports every fill, the open position, signed realised P&L and a trade count for display and logging.

## Interface
- `BUY_THRESH`, default 60: enter long when ask `sell_price` <= this value.
- `TAKE_PROFIT`, default 8: exit when bid >= entry + TAKE_PROFIT.
- `STOP_LOSS`, default 6: exit when bid + STOP_LOSS <= entry.
- `COOLDOWN_Q`, default 2: number of new quotes ignored after an exit.
- `clk` in 1: system clock. Single clock domain; no derived clocks.
- `reset` in 1: synchronous, active-high.
- `buy_price` in 8: current bid, unsigned.
- `sell_price` in 8: current ask, unsigned.
- `trade_valid` out 1: one-cycle pulse per fill.
- `trade_side` out 1: side of the fill, 0 = buy, 1 = sell. Valid when `trade_valid` is high, otherwise holds its last value.
- `trade_price` out 8: fill price. Valid with `trade_valid`, otherwise holds.
- `long_pos` out 1: 1 while holding one unit.
- `entry_price` out 8: ask paid on the open position. 0 while flat.
- `pnl` out 16: signed two's-complement realised P&L.
- `trade_count` out 16: total fills, saturating at 65535.
- `state` out 2: FSM state, 0 = FLAT, 1 = LONG, 2 = COOLDOWN.

## Operation
- **Quote stage**
  - Register the inputs into `q_bid`/`q_ask` every cycle.
  - `q_new` pulses for one cycle when the registered pair differs from the previous registered pair.
  - The first sample after reset always counts as new. It is tracked with an internal `seen` flag cleared by reset.
  - An unchanged pair never produces `q_new`, however long it is held.
- **FSM** acts only in cycles where `q_new` = 1. In all other cycles every register holds its value.
- **FLAT**
  - If `q_ask <= BUY_THRESH`: buy fill at `q_ask`, set `entry_price = q_ask`, set `long_pos` = 1, go to LONG.
  - Otherwise stay in FLAT.
- **LONG**
  - Compare in 9 bits so nothing wraps.
  - Exit if `q_bid >= entry + TAKE_PROFIT`, or if `q_bid + STOP_LOSS <= entry`. Take-profit has priority when both hold.
  - On exit: sell fill at `q_bid`, `pnl += q_bid - entry`, set `long_pos` = 0, set `entry_price` = 0, load the cooldown counter with COOLDOWN_Q, go to COOLDOWN.
  - If neither condition holds, stay in LONG.
- **COOLDOWN**
  - Each `q_new` decrements the counter.
  - The quote that takes the counter from 1 to 0 is consumed, not evaluated; the FSM goes to FLAT.
  - If COOLDOWN_Q = 0, go straight to FLAT on the exit cycle.
- **P&L arithmetic**
  - Sign-extend `q_bid - entry` to 17 bits and add to `pnl`.
  - Saturate at +32767 and -32768.
- **Trade count**
  - `trade_count` increments on every fill, buy or sell, and saturates at 65535.
- **Reset**
  - Values after reset: `trade_valid`=0, `trade_side`=0, `trade_price`=0, `long_pos`=0, `entry_price`=0, `pnl`=0, `trade_count`=0, `state`=FLAT.
  - The cooldown counter, `seen` flag and quote registers are also cleared.
  - Reset during LONG discards the open position without emitting a fill.
  - Reset takes priority over a simultaneous `q_new`.

## Timing
- The input pair changes and is sampled at edge N. `q_new` is high after edge N.
- The FSM acts at edge N+1. `trade_valid` and all updated outputs are visible after edge N+1, so latency is 2 cycles.
- `trade_valid` is high for exactly one cycle per fill. At most one fill per new quote.
- A buy and a sell can never both occur on the same quote.
- Inputs may change on any cycle. Back-to-back new quotes in consecutive cycles are each evaluated.
- The upstream feed updates roughly once every 2^21 cycles; the block does not rely on that spacing.

## Test plan
1. **Entry fill.** Release reset with bid=70, ask=58 held.
   - Expect `trade_valid` 2 cycles after the first sample, with side=0, price=58.
   - Then `long_pos`=1, `entry_price`=58, `trade_count`=1, `state`=LONG.
   - No further fill while the pair is held.
2. **Take-profit.** From test 1, apply bid=66, ask=70.
   - Sell fill at 66, `pnl`=+8, `trade_count`=2, `state`=COOLDOWN, `entry_price`=0.
   - Repeat with bid=65: no fill, because 65 < 66.
3. **Stop-loss.** Enter at ask 60, then apply bid=54.
   - Sell at 54, `pnl` decreases by 6.
   - Bid=55 instead produces no fill, because 55+6 > 60.
4. **Cooldown.** After an exit with COOLDOWN_Q=2, present two new quotes with ask=55.
   - No fill; `state` returns to FLAT after the second quote.
   - A third new quote with ask=55 produces a buy fill at 55.
5. **Saturation.** Force repeated losing round trips, entry 86 and exit 0 each time, with STOP_LOSS=1 and COOLDOWN_Q=0.
   - `pnl` clamps at -32768 and never wraps positive.
   - Preload `trade_count` at 65534: the next two fills leave it at 65535.
6. **Reset mid-position.** Assert `reset` for one cycle while LONG, coincident with a take-profit quote.
   - No `trade_valid`.
   - Next cycle all outputs are at their reset values and `state`=FLAT.
   - The held pair is then re-treated as a first quote.
